sha256_compress: RTL and testbench

SHA256_COMPRESS -- requirements
Module: sha256_compress

---
 rtl/sha256_pkg.sv | 30 +++
 rtl/sha256_functions.sv | 19 +
 rtl/sha256_compress.sv | 82 ++++++++
 tb/tb_sha256_compress.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 word type, initial hash, FSM states and round functions
package sha256_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
  localparam word_t H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha256_functions.sv
// sha256_functions: SHA-256 round-constant ROM indexed by round number
module sha256_functions
  import sha256_pkg::*;
(
  input  logic [6:0] j,
  output word_t      k_j
);
  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  assign k_j = j[6] ? '0 : K[j[5:0]];
endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: one-round-per-cycle SHA-256 block compressor; define SHA256_CHAIN_EN to add the chain input
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef SHA256_CHAIN_EN
  input  logic         chain,
`endif
  input  logic [511:0] block_in,
  output logic         ready,
  output logic         done,
  output logic [255:0] digest
);
  state_t state;
  logic [6:0] j;
  logic use_chain;
  word_t s [8];
  word_t w [16];
  word_t iv [8];
  word_t init [8];
  word_t k_j, t1, t2, w_new;
`ifdef SHA256_CHAIN_EN
  assign use_chain = chain;
`else
  assign use_chain = 1'b0;
`endif
  sha256_functions u_rom (.j(j), .k_j(k_j));
  assign ready = state == IDLE;
  always_comb begin
    t1 = s[7] + big_sigma1(s[4]) + ch(s[4], s[5], s[6]) + k_j + w[0];
    t2 = big_sigma0(s[0]) + maj(s[0], s[1], s[2]);
    w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    for (int i = 0; i < 8; i++) init[i] = use_chain ? digest[255-32*i -: 32] : H0[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      j <= '0;
      done <= 1'b0;
      digest <= '0;
      for (int i = 0; i < 8; i++) begin
        s[i] <= '0;
        iv[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          for (int i = 0; i < 8; i++) begin
            s[i] <= init[i];
            iv[i] <= init[i];
          end
          for (int i = 0; i < 16; i++) w[i] <= block_in[511-32*i -: 32];
          j <= '0;
          state <= ROUND;
        end
        ROUND: begin
          s[0] <= t1 + t2;
          s[1] <= s[0];
          s[2] <= s[1];
          s[3] <= s[2];
          s[4] <= s[3] + t1;
          s[5] <= s[4];
          s[6] <= s[5];
          s[7] <= s[6];
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= w_new;
          j <= j + 7'd1;
          if (j == 7'd63) state <= FINAL;
        end
        default: begin
          for (int i = 0; i < 8; i++) digest[255-32*i -: 32] <= iv[i] + s[i];
          done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: randomized and known-vector checks of sha256_compress against a behavioural SHA-256 model
module tb_sha256_compress;
  localparam logic [255:0] IV0 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] M1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] M2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] M_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic clk = 1'b0;
  logic rst, start, chain;
  logic [511:0] block_in;
  logic ready, done;
  logic [255:0] digest;
  logic [255:0] cur;
  int checks = 0;
  int failures = 0;
  sha256_compress dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef SHA256_CHAIN_EN
    .chain(chain),
`endif
    .block_in(block_in),
    .ready(ready),
    .done(done),
    .digest(digest)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] ref_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] nv [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      nv = '{t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
      v = nv;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
    return r;
  endfunction
  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction
  task automatic run_block(input logic [511:0] blk, input logic ch, input logic hammer,
                           input logic [255:0] exp, input string tag);
    int lat;
    int rdy;
    logic [255:0] mid;
    start = 1'b1;
    block_in = blk;
    chain = ch;
    @(posedge clk);
    #1;
    start = hammer;
    chain = 1'b0;
    block_in = rand_block();
    lat = -1;
    rdy = 0;
    mid = 'x;
    for (int n = 0; n < 200 && lat < 0; n++) begin
      @(negedge clk);
      if (done) lat = n;
      else rdy += int'(ready);
      if (n == 64) begin
        mid = digest;
        start = 1'b0;
      end
    end
    check({tag, "_latency"}, 256'(lat), 256'(65));
    check({tag, "_digest"}, digest, exp);
    check({tag, "_ready_busy"}, 256'(rdy), 256'(0));
    check({tag, "_digest_hold"}, mid, cur);
    @(negedge clk);
    check({tag, "_done_pulse"}, 256'(done), 256'(0));
    cur = exp;
  endtask
  initial begin
    logic [511:0] blk;
    int dn, first, second, rdy;
    rst = 1'b1;
    start = 1'b1;
    chain = 1'b0;
    block_in = ABC;
    cur = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 256'(ready), 256'(1));
    check("rst_done", 256'(done), 256'(0));
    check("rst_digest", digest, '0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_ready", 256'(ready), 256'(1));
    run_block(ABC, 1'b0, 1'b0, ABC_DIG, "abc");
    run_block(EMPTY, 1'b0, 1'b0, EMPTY_DIG, "empty");
    for (int r = 0; r < 4; r++) begin
      blk = rand_block();
      run_block(blk, 1'b0, 1'b0, ref_compress(IV0, blk), $sformatf("rand%0d", r));
    end
    run_block(ABC, 1'b0, 1'b1, ABC_DIG, "abc_hammer");
    dn = 0;
    repeat (70) begin
      @(negedge clk);
      dn += int'(done);
    end
    check("hammer_extra_done", 256'(dn), 256'(0));
    check("hammer_digest", digest, ABC_DIG);
    start = 1'b1;
    block_in = ABC;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (31) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_digest_clr", digest, '0);
    check("abort_ready", 256'(ready), 256'(1));
    rst = 1'b0;
    cur = '0;
    dn = 0;
    repeat (100) begin
      @(negedge clk);
      dn += int'(done);
    end
    check("abort_no_done", 256'(dn), 256'(0));
    check("abort_digest_zero", digest, '0);
    run_block(ABC, 1'b0, 1'b0, ABC_DIG, "abc_after_rst");
    start = 1'b1;
    block_in = ABC;
    first = -1;
    second = -1;
    rdy = 0;
    for (int n = 0; n < 300 && second < 0; n++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = n;
        else begin
          second = n;
          start = 1'b0;
        end
      end else if (first >= 0) rdy += int'(ready);
    end
    start = 1'b0;
    check("b2b_first_latency", 256'(first), 256'(65));
    check("b2b_gap", 256'(second - first), 256'(66));
    check("b2b_ready_between", 256'(rdy), 256'(0));
    check("b2b_digest", digest, ABC_DIG);
    cur = ABC_DIG;
    @(negedge clk);
`ifdef SHA256_CHAIN_EN
    run_block(M1, 1'b0, 1'b0, ref_compress(IV0, M1), "chain_b1");
    run_block(M2, 1'b1, 1'b0, M_DIG, "chain_b2");
    blk = rand_block();
    run_block(blk, 1'b1, 1'b0, ref_compress(cur, blk), "chain_rand");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
